// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, FSM states,
// mux/ALU select codes and the per-state control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXEC = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // fetch_ld and branch are qualifiers resolved against mem_ready / zero in the top
    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       fetch_ld;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control word lookup; pure Moore part of the controller.
module mc_ctrl_decode
    import mips_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.fetch_ld = 1'b1;
                ctrl_o.alusrcb  = ALUB_FOUR;
            end
            S_DECODE: ctrl_o.alusrcb = ALUB_IMM;
            S_MEMADR, S_ADDIEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_req  = 1'b1;
                ctrl_o.memwrite = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_RTEXEC: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = ALUB_RT;
                ctrl_o.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.regdst   = 1'b1;
            end
            S_BEQ: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
            end
            S_ADDIWB: ctrl_o.regwrite = 1'b1;
            S_JUMP: begin
                ctrl_o.pcsrc   = PCSRC_JUMP;
                ctrl_o.pcwrite = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: state register, next-state logic and output gating.
// Memory states stall on mem_ready; reset forces every output low immediately.
module multicycle_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcwrite,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   illegal;

    mc_ctrl_decode u_decode (
        .state_i (state_q),
        .ctrl_o  (ctrl)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        illegal = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTEXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_RTEXEC: state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Reset overrides the current state so nothing is enabled before the reset edge lands
    always_comb begin
        mem_req    = 1'b0;
        memwrite   = 1'b0;
        iord       = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        pcsrc      = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        aluop      = 2'b00;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite   = 1'b0;
        illegal_op = 1'b0;
        state      = S_FETCH;
        if (!reset) begin
            mem_req    = ctrl.mem_req;
            memwrite   = ctrl.memwrite;
            iord       = ctrl.iord;
            irwrite    = ctrl.fetch_ld & mem_ready;
            pcwrite    = (ctrl.fetch_ld & mem_ready) | ctrl.pcwrite | (ctrl.branch & zero);
            pcsrc      = ctrl.pcsrc;
            alusrca    = ctrl.alusrca;
            alusrcb    = ctrl.alusrcb;
            aluop      = ctrl.aluop;
            regdst     = ctrl.regdst;
            memtoreg   = ctrl.memtoreg;
            regwrite   = ctrl.regwrite;
            illegal_op = illegal;
            state      = state_q;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed-vector bench for multicycle_controller; each vector row is one clock cycle.
module tb_multicycle_controller;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, memwrite, iord, irwrite, pcwrite;
    logic [1:0] pcsrc, alusrcb, aluop;
    logic       alusrca, regdst, memtoreg, regwrite, illegal_op;
    logic [3:0] state;

    int vecs = 0;
    int miscompares = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcwrite(pcwrite), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    logic [19:0] obs;
    assign obs = {state, mem_req, memwrite, iord, irwrite, pcwrite, pcsrc, alusrca,
                  alusrcb, aluop, regdst, memtoreg, regwrite, illegal_op};

    // low 16 bits grouped: [mem_req memwrite iord irwrite][pcwrite pcsrc alusrca][alusrcb aluop][regdst memtoreg regwrite illegal_op]
    localparam logic [19:0] E_RESET   = 20'h0;
    localparam logic [19:0] E_FETCH_W = {S_FETCH,  16'b1000_0000_0100_0000};
    localparam logic [19:0] E_FETCH_R = {S_FETCH,  16'b1001_1000_0100_0000};
    localparam logic [19:0] E_DEC     = {S_DECODE, 16'b0000_0000_1000_0000};
    localparam logic [19:0] E_DEC_ILL = {S_DECODE, 16'b0000_0000_1000_0001};
    localparam logic [19:0] E_MEMADR  = {S_MEMADR, 16'b0000_0001_1000_0000};
    localparam logic [19:0] E_MEMRD   = {S_MEMRD,  16'b1010_0000_0000_0000};
    localparam logic [19:0] E_MEMWB   = {S_MEMWB,  16'b0000_0000_0000_0110};
    localparam logic [19:0] E_MEMWR   = {S_MEMWR,  16'b1110_0000_0000_0000};
    localparam logic [19:0] E_RTEXEC  = {S_RTEXEC, 16'b0000_0001_0010_0000};
    localparam logic [19:0] E_ALUWB   = {S_ALUWB,  16'b0000_0000_0000_1010};
    localparam logic [19:0] E_BEQ_T   = {S_BEQ,    16'b0000_1011_0001_0000};
    localparam logic [19:0] E_BEQ_N   = {S_BEQ,    16'b0000_0011_0001_0000};
    localparam logic [19:0] E_ADDIEX  = {S_ADDIEX, 16'b0000_0001_1000_0000};
    localparam logic [19:0] E_ADDIWB  = {S_ADDIWB, 16'b0000_0000_0000_0010};
    localparam logic [19:0] E_JUMP    = {S_JUMP,   16'b0000_1100_0000_0000};

    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct packed {
        logic        rst;
        logic        mr;
        logic        z;
        logic [5:0]  op;
        logic [19:0] exp;
    } vec_t;

    task automatic test_reset();
        vec_t v [2];
        v = '{ {1'b1, 1'b1, 1'b1, OP_LW, E_RESET},
               {1'b1, 1'b1, 1'b1, OP_SW, E_RESET} };
        foreach (v[i]) begin
            reset = v[i].rst; mem_ready = v[i].mr; zero = v[i].z; op = v[i].op; #1;
            vecs++;
            if (obs !== v[i].exp) begin
                miscompares++;
                $display("FAIL reset[%0d] got %h want %h", i, obs, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    // op is scrambled outside DECODE/MEMADR to show it is ignored there
    task automatic test_lw();
        vec_t v [6];
        v = '{ {1'b0, 1'b1, 1'b0, OP_BAD, E_FETCH_R},
               {1'b0, 1'b1, 1'b0, OP_LW,  E_DEC},
               {1'b0, 1'b1, 1'b0, OP_LW,  E_MEMADR},
               {1'b0, 1'b1, 1'b0, OP_SW,  E_MEMRD},
               {1'b0, 1'b1, 1'b0, OP_BAD, E_MEMWB},
               {1'b0, 1'b0, 1'b0, OP_J,   E_FETCH_W} };
        foreach (v[i]) begin
            reset = v[i].rst; mem_ready = v[i].mr; zero = v[i].z; op = v[i].op; #1;
            vecs++;
            if (obs !== v[i].exp) begin
                miscompares++;
                $display("FAIL lw[%0d] got %h want %h", i, obs, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_stall();
        vec_t v [8];
        v = '{ {1'b0, 1'b1, 1'b0, OP_SW, E_FETCH_R},
               {1'b0, 1'b1, 1'b0, OP_SW, E_DEC},
               {1'b0, 1'b1, 1'b0, OP_SW, E_MEMADR},
               {1'b0, 1'b0, 1'b0, OP_LW, E_MEMWR},
               {1'b0, 1'b0, 1'b1, OP_LW, E_MEMWR},
               {1'b0, 1'b0, 1'b0, OP_LW, E_MEMWR},
               {1'b0, 1'b1, 1'b0, OP_LW, E_MEMWR},
               {1'b0, 1'b0, 1'b0, OP_LW, E_FETCH_W} };
        foreach (v[i]) begin
            reset = v[i].rst; mem_ready = v[i].mr; zero = v[i].z; op = v[i].op; #1;
            vecs++;
            if (obs !== v[i].exp) begin
                miscompares++;
                $display("FAIL sw_stall[%0d] got %h want %h", i, obs, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_beq();
        vec_t v [8];
        v = '{ {1'b0, 1'b1, 1'b0, OP_BEQ, E_FETCH_R},
               {1'b0, 1'b1, 1'b0, OP_BEQ, E_DEC},
               {1'b0, 1'b1, 1'b1, OP_BEQ, E_BEQ_T},
               {1'b0, 1'b1, 1'b1, OP_BEQ, E_FETCH_R},
               {1'b0, 1'b1, 1'b1, OP_BEQ, E_DEC},
               {1'b0, 1'b1, 1'b0, OP_BEQ, E_BEQ_N},
               {1'b0, 1'b0, 1'b0, OP_BEQ, E_FETCH_W},
               {1'b0, 1'b0, 1'b1, OP_BEQ, E_FETCH_W} };
        foreach (v[i]) begin
            reset = v[i].rst; mem_ready = v[i].mr; zero = v[i].z; op = v[i].op; #1;
            vecs++;
            if (obs !== v[i].exp) begin
                miscompares++;
                $display("FAIL beq[%0d] got %h want %h", i, obs, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        vec_t v [4];
        v = '{ {1'b0, 1'b1, 1'b0, OP_BAD,  E_FETCH_R},
               {1'b0, 1'b1, 1'b0, OP_BAD,  E_DEC_ILL},
               {1'b0, 1'b0, 1'b0, OP_BAD,  E_FETCH_W},
               {1'b0, 1'b0, 1'b0, 6'h3e,   E_FETCH_W} };
        foreach (v[i]) begin
            reset = v[i].rst; mem_ready = v[i].mr; zero = v[i].z; op = v[i].op; #1;
            vecs++;
            if (obs !== v[i].exp) begin
                miscompares++;
                $display("FAIL illegal[%0d] got %h want %h", i, obs, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype_addi_j();
        vec_t v [13];
        v = '{ {1'b0, 1'b1, 1'b0, OP_RTYPE, E_FETCH_R},
               {1'b0, 1'b1, 1'b0, OP_RTYPE, E_DEC},
               {1'b0, 1'b1, 1'b0, OP_LW,    E_RTEXEC},
               {1'b0, 1'b1, 1'b0, OP_LW,    E_ALUWB},
               {1'b0, 1'b1, 1'b0, OP_ADDI,  E_FETCH_R},
               {1'b0, 1'b1, 1'b0, OP_ADDI,  E_DEC},
               {1'b0, 1'b1, 1'b0, OP_ADDI,  E_ADDIEX},
               {1'b0, 1'b1, 1'b0, OP_ADDI,  E_ADDIWB},
               {1'b0, 1'b1, 1'b0, OP_J,     E_FETCH_R},
               {1'b0, 1'b1, 1'b0, OP_J,     E_DEC},
               {1'b0, 1'b1, 1'b0, OP_J,     E_JUMP},
               {1'b0, 1'b0, 1'b0, OP_J,     E_FETCH_W},
               {1'b0, 1'b0, 1'b0, OP_J,     E_FETCH_W} };
        foreach (v[i]) begin
            reset = v[i].rst; mem_ready = v[i].mr; zero = v[i].z; op = v[i].op; #1;
            vecs++;
            if (obs !== v[i].exp) begin
                miscompares++;
                $display("FAIL rtype_addi_j[%0d] got %h want %h", i, obs, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_midmem();
        vec_t v [7];
        v = '{ {1'b0, 1'b1, 1'b0, OP_LW, E_FETCH_R},
               {1'b0, 1'b1, 1'b0, OP_LW, E_DEC},
               {1'b0, 1'b1, 1'b0, OP_LW, E_MEMADR},
               {1'b0, 1'b0, 1'b0, OP_LW, E_MEMRD},
               {1'b1, 1'b0, 1'b0, OP_LW, E_RESET},
               {1'b1, 1'b1, 1'b1, OP_LW, E_RESET},
               {1'b0, 1'b0, 1'b0, OP_LW, E_FETCH_W} };
        foreach (v[i]) begin
            reset = v[i].rst; mem_ready = v[i].mr; zero = v[i].z; op = v[i].op; #1;
            vecs++;
            if (obs !== v[i].exp) begin
                miscompares++;
                $display("FAIL reset_midmem[%0d] got %h want %h", i, obs, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_stall();
        vec_t v [6];
        v = '{ {1'b0, 1'b0, 1'b0, OP_J, E_FETCH_W},
               {1'b0, 1'b0, 1'b1, OP_J, E_FETCH_W},
               {1'b0, 1'b1, 1'b0, OP_J, E_FETCH_R},
               {1'b0, 1'b1, 1'b0, OP_J, E_DEC},
               {1'b0, 1'b1, 1'b0, OP_J, E_JUMP},
               {1'b0, 1'b0, 1'b0, OP_J, E_FETCH_W} };
        foreach (v[i]) begin
            reset = v[i].rst; mem_ready = v[i].mr; zero = v[i].z; op = v[i].op; #1;
            vecs++;
            if (obs !== v[i].exp) begin
                miscompares++;
                $display("FAIL fetch_stall[%0d] got %h want %h", i, obs, v[i].exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq();
        test_illegal();
        test_rtype_addi_j();
        test_reset_midmem();
        test_fetch_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
